// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the alu_mc block.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_DIVU = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/alu_if.sv
// Command/result handshake bundle between an ALU client (master) and alu_mc (slave).
interface alu_if #(
   parameter int WIDTH = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] op1;
   logic signed [WIDTH-1:0] op2;
   logic [3:0]              alu_op;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] result;
   logic                    zero;

   modport master (
      output in_valid, op1, op2, alu_op, out_ready,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  in_valid, op1, op2, alu_op, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative unit: shift-add multiply (low half) or restoring unsigned divide, one bit per cycle.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);
   localparam int CNT_W = $clog2(WIDTH);

   logic             busy_q, div_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] sh_q, sh_d, b_q, b_d;
   logic [WIDTH:0]   acc_q, acc_d, rem_sh, diff;

   // sh holds multiplier / dividend-then-quotient; acc holds product / partial remainder
   always_comb begin
      rem_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, b_q};
      if (div_q) begin
         b_d   = b_q;
         sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
         acc_d = diff[WIDTH] ? rem_sh : diff;
      end else begin
         b_d   = b_q << 1;
         sh_d  = sh_q >> 1;
         acc_d = sh_q[0] ? acc_q + {1'b0, b_q} : acc_q;
      end
   end

   assign done_o   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign result_o = div_q ? sh_d : acc_d[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         sh_q   <= '0;
         b_q    <= '0;
         acc_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         div_q  <= div_i;
         cnt_q  <= '0;
         sh_q   <= a_i;
         b_q    <= b_i;
         acc_q  <= '0;
      end else if (busy_q) begin
         sh_q   <= sh_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_q + CNT_W'(1);
         if (done_o) busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake; MUL/DIVU exist only when ALU_MC_MULDIV_EN is defined.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);
   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] res_q, res_d;

   function automatic logic signed [WIDTH-1:0] alu_fn(input logic [3:0]              op,
                                                      input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
      logic [SHAMT_W-1:0]      sh;
      logic signed [WIDTH-1:0] r;
      sh = b[SHAMT_W-1:0];
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SRL:  r = $signed($unsigned(a) >> sh);
         OP_SLL:  r = a << sh;
         OP_SRA:  r = a >>> sh;
         default: r = '0;
      endcase
      return r;
   endfunction

`ifdef ALU_MC_MULDIV_EN
   logic             md_start, md_done;
   logic [WIDTH-1:0] md_result;

   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start_i  (md_start),
      .div_i    (bus.alu_op == OP_DIVU),
      .a_i      (bus.op1),
      .b_i      (bus.op2),
      .done_o   (md_done),
      .result_o (md_result)
   );
`endif

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
`ifdef ALU_MC_MULDIV_EN
      md_start = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
`ifdef ALU_MC_MULDIV_EN
               if (is_muldiv(bus.alu_op)) begin
                  state_d  = CALC;
                  md_start = 1'b1;
               end else
`endif
               begin
                  state_d = DONE;
                  res_d   = alu_fn(bus.alu_op, bus.op1, bus.op2);
               end
            end
         end
`ifdef ALU_MC_MULDIV_EN
         CALC: begin
            if (md_done) begin
               state_d = DONE;
               res_d   = $signed(md_result);
            end
         end
`endif
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: transaction-level reference model, per-cycle compare, literal vectors.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef ALU_MC_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif
   localparam int MD_LAT = MD_EN ? W + 1 : 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_if #(.WIDTH(W)) bus ();
   alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int passed = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
   endtask

   // Reference: results straight from the opcode definitions in plain arithmetic
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0101: return a ^ b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000: return a >> b[4:0];
         4'b1001: return a << b[4:0];
         4'b1010: return $signed(a) >>> b[4:0];
         4'b0011: begin
            p = {32'd0, a} * {32'd0, b};
            return MD_EN ? p[31:0] : 32'd0;
         end
         4'b0111: begin
            if (!MD_EN) return 32'd0;
            return (b == 0) ? 32'hFFFF_FFFF : a / b;
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op);
      return (op == 4'b0011 || op == 4'b0111) ? MD_LAT : 1;
   endfunction

   // Transaction model: idle / waiting N cycles / holding a result until taken
   bit          m_idle = 1'b1;
   bit          m_vld  = 1'b0;
   int          m_cnt  = 0;
   logic [31:0] m_res  = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle = 1'b1;
         m_vld  = 1'b0;
         m_cnt  = 0;
         m_res  = '0;
      end else if (m_idle) begin
         if (bus.in_valid) begin
            m_idle = 1'b0;
            m_res  = ref_alu(bus.alu_op, bus.op1, bus.op2);
            m_cnt  = ref_lat(bus.alu_op) - 1;
            m_vld  = (m_cnt == 0);
         end
      end else if (!m_vld) begin
         m_cnt--;
         if (m_cnt == 0) m_vld = 1'b1;
      end else if (bus.out_ready) begin
         m_vld  = 1'b0;
         m_idle = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_idle});
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
         if (m_vld) begin
            chk("result", bus.result, m_res);
            chk("zero", {31'd0, bus.zero}, {31'd0, (m_res == 0)});
         end
      end
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      int          hold;
      bit          noise;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input int hold, input bit noise);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.hold = hold; v.noise = noise;
      vecs.push_back(v);
   endtask

   task automatic run(input vec_t v, input int idx);
      int n;
      bus.alu_op   = v.op;
      bus.op1      = v.a;
      bus.op2      = v.b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (v.noise) begin
         bus.in_valid = 1'b1;
         bus.alu_op   = 4'b0010;
         bus.op1      = 32'd9;
         bus.op2      = 32'd9;
      end
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.out_valid) begin
         chk($sformatf("timeout_v%0d", idx), 32'd0, 32'd1);
      end else begin
         chk($sformatf("latency_v%0d", idx), n + 1, v.lat);
         chk($sformatf("literal_v%0d", idx), bus.result, v.exp);
      end
      repeat (v.hold) begin
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_op    = '0;
      bus.op1       = '0;
      bus.op2       = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", {31'd0, bus.zero}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      cmp_en = 1'b1;

      // out_ready with nothing pending must be harmless
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      add(4'b0010, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1, 0, 0);
      add(4'b0110, 32'd5,         32'd5,        32'd0,         1, 3, 0);
      add(4'b1010, 32'h8000_0000, 32'h24,       32'hF800_0000, 1, 0, 0);
      add(4'b0100, 32'hFFFF_FFFF, 32'h1,        32'd1,         1, 0, 0);
      add(4'b0100, 32'h1,         32'hFFFF_FFFF, 32'd0,        1, 0, 0);
      add(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 0, 0);
      add(4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, 1, 0);
      add(4'b0101, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1, 0, 1);
      add(4'b1000, 32'h8000_0000, 32'h4,        32'h0800_0000, 1, 0, 0);
      add(4'b1001, 32'h1,         32'h3F,       32'h8000_0000, 1, 0, 0);
      add(4'b0110, 32'd0,         32'd1,        32'hFFFF_FFFF, 1, 0, 0);
      add(4'b1111, 32'd7,         32'd3,        32'd0,         1, 0, 0);
      add(4'b1011, 32'd7,         32'd3,        32'd0,         1, 0, 0);
      add(4'b0011, 32'h0000_FFFF, 32'h0001_0001, MD_EN ? 32'hFFFF_FFFF : 32'd0, MD_LAT, 2, 1);
      add(4'b0111, 32'd100,       32'd7,        MD_EN ? 32'd14 : 32'd0,         MD_LAT, 0, 1);
      add(4'b0111, 32'd12345,     32'd0,        MD_EN ? 32'hFFFF_FFFF : 32'd0,  MD_LAT, 0, 0);
      add(4'b0011, 32'd3,         32'd4,        MD_EN ? 32'd12 : 32'd0,         MD_LAT, 0, 0);

      foreach (vecs[i]) run(vecs[i], i);

      // Abort a divide with reset part-way through CALC
      bus.alu_op   = 4'b0111;
      bus.op1      = 32'd1000;
      bus.op2      = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("abort_result", bus.result, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_late_valid", {31'd0, bus.out_valid}, 32'd0);
      add(4'b0010, 32'd1, 32'd2, 32'd3, 1, 0, 0);
      run(vecs[vecs.size() - 1], vecs.size() - 1);

      repeat (2) @(posedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal values are 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), SHALL set the number of op2 LSBs used as the shift amount.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that op1, op2 and alu_op are valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a command this cycle.
REQ-007 op1, op2  input  WIDTH  SHALL be signed operands.
REQ-008 alu_op  input  4  SHALL select the operation per REQ-013.
REQ-009 out_valid  output  1  SHALL indicate that result and zero are valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-011 result  output  WIDTH  SHALL carry the registered, signed operation result.
REQ-012 zero  output  1  SHALL be 1 exactly when result == 0.

Function
REQ-013 Opcodes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0100, XOR 0101, SRL 1000, SLL 1001, SRA 1010, MUL 0011, DIVU 0111; any other code SHALL yield result 0.
REQ-014 A command SHALL be accepted only on a cycle with in_valid && in_ready, and the operands SHALL be captured on that cycle.
REQ-015 The FSM SHALL have the states IDLE, CALC and DONE; in_ready SHALL equal (state == IDLE).
REQ-016 Single-cycle ops: IDLE->DONE on accept; out_valid SHALL rise on the cycle after accept (latency 1).
REQ-017 MUL/DIVU: IDLE->CALC on accept, CALC lasts exactly WIDTH cycles, then CALC->DONE; out_valid SHALL rise WIDTH+1 cycles after accept.
REQ-018 DONE SHALL hold result, zero and out_valid stable until out_ready is high; DONE->IDLE on out_ready, giving a throughput of at most one command per two cycles.
REQ-019 in_valid during CALC or DONE SHALL be ignored, with no command captured.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-021 SLT SHALL be a signed compare producing 1 or 0, zero-extended.
REQ-022 Shifts SHALL use op2[SHAMT_W-1:0]; SRA SHALL be sign-filling and SRL/SLL zero-filling.
REQ-023 MUL SHALL be iterative shift-add and SHALL return the low WIDTH bits of the unsigned product.
REQ-024 DIVU SHALL be restoring unsigned division returning the quotient; for op2 == 0 the result SHALL be all ones and still take WIDTH cycles.
REQ-025 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-026 On rst: state IDLE, out_valid 0, result 0, zero 1, in_ready 1 after release, and internal counters and accumulators cleared.
REQ-027 rst asserted in CALC or DONE SHALL abort the operation; no result SHALL be emitted after release.

Configuration
REQ-028 Macro ALU_MC_MULDIV_EN defined: MUL and DIVU SHALL be implemented per REQ-017/023/024.
REQ-029 Macro undefined: the CALC state and iterative hardware SHALL be absent, and MUL/DIVU SHALL behave as unknown opcodes (result 0, latency 1).

Structure
REQ-030 Package alu_pkg SHALL hold the opcode localparams (or a 4-bit enum) and the state typedef {IDLE, CALC, DONE}.
REQ-031 The iterative multiply/divide datapath SHALL be sub-module alu_muldiv (start, op select, operands in; done, result out), instantiated only under ALU_MC_MULDIV_EN.

Verification
REQ-032 ADD 0x7FFFFFFF + 1, out_ready = 1 -> out_valid one cycle after accept, result 0x80000000, zero 0.
REQ-033 SUB 5 - 5 with out_ready held 0 for 3 cycles -> result 0 and zero 1 held stable, in_ready 0 until the cycle after out_ready rises.
REQ-034 SRA 0x80000000 by op2 = 0x24 (shamt 4) -> 0xF8000000; SLT -1 < 1 -> 1.
REQ-035 MUL 0xFFFF * 0x10001 -> 0xFFFFFFFF after 33 cycles; DIVU 100 / 7 -> 14; DIVU x / 0 -> 0xFFFFFFFF.
REQ-036 rst pulse at CALC cycle 10 of a DIVU -> out_valid stays 0 and the next ADD 1 + 2 returns 3 correctly.
REQ-037 Macro undefined: MUL 3 * 4 -> result 0, zero 1, latency 1; opcode 1111 -> result 0.
